// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the hex-to-segment table for the 7-seg scan driver
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  // active-high codes, entry 15 first so SEG_TABLE[n] is the code for nibble n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to segment pattern with blanking and output polarity
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  logic [6:0] w_seg_hi;
  assign w_seg_hi = i_blank ? 7'h00 : hex_to_seg(i_nibble);
  assign o_seg = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered 4-digit time-multiplexed seven-segment driver
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [15:0]           value,
  input  logic [3:0]            dp_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_OFF = ACTIVE_LOW;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [1:0]            r_idx;
  logic [19:0]           r_shadow;
  logic [19:0]           r_disp;
  logic                  r_pending;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;
  logic                  w_tick;
  logic                  w_boundary;
  logic [19:0]           w_load_word;
  logic [15:0]           w_vals;
  logic [3:0]            w_dps;
  logic [3:0]            w_nibble;
  logic [3:0]            w_lz;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [6:0]            w_seg;
  assign w_tick      = en && (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_boundary  = w_tick && (r_idx == 2'd3);
  assign w_load_word = {dp_in, value};
  assign w_vals      = r_disp[15:0];
  assign w_dps       = r_disp[19:16];
  assign w_nibble    = w_vals[{r_idx, 2'b00} +: 4];
  // w_lz[k]: nibbles k..3 are all zero; digit 0 never counts as a leading zero
  assign w_lz        = {w_vals[15:12] == 4'h0, w_vals[15:8] == 8'h0, w_vals[15:4] == 12'h0, 1'b0};
  assign w_blank     = !en || (BLANK_LZ && w_lz[r_idx]);
  assign w_onehot    = NUM_DIGITS'(1) << r_idx;
  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_decode (
    .i_nibble(w_nibble),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_disp       <= '0;
      r_pending    <= 1'b0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (en) r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      r_frame_done <= w_boundary;
      if (load) r_shadow <= w_load_word;
      // a load landing on the boundary bypasses the shadow so it is not delayed a frame
      if (load && w_boundary) r_disp <= w_load_word;
      else if (w_boundary && r_pending) r_disp <= r_shadow;
      r_pending <= load ? !w_boundary : (w_boundary ? 1'b0 : r_pending);
      r_an      <= w_blank ? AN_OFF : (ACTIVE_LOW ? ~w_onehot : w_onehot);
      r_seg     <= w_seg;
      r_dp      <= (!w_blank && w_dps[r_idx]) ^ ACTIVE_LOW;
    end
  end
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
endmodule
